// File: rtl/motor_ramp_sched.sv
// Slew-rate scheduler for left/right PWM speed commands: bounded step per tick,
// a zero-speed brake dwell before any reversal, and a level emergency stop.
module motor_ramp_sched #(
  parameter int STEP      = 32,
  parameter int TICK_DIV  = 1000,
  parameter int BRAKE_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] lft_tgt,
  input  logic signed [10:0] rht_tgt,
  input  logic               tgt_vld,
  input  logic               estop,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               at_tgt,
  output logic               busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(BRAKE_CYC - 1);
  localparam logic signed [11:0] STEP_S   = 12'(STEP);
  localparam logic signed [11:0] MAX_S    = 12'sd1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } side_st_t;

  // -1024 has no positive mirror, so it is folded onto -1023
  function automatic logic signed [10:0] clamp_tgt(input logic signed [10:0] t);
    return (t == 11'sh400) ? 11'sh401 : t;
  endfunction

  function automatic logic signed [10:0] sat12(input logic signed [11:0] v);
    if (v > MAX_S)  return 11'sd1023;
    if (v < -MAX_S) return -11'sd1023;
    return v[10:0];
  endfunction

  function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
    return (v < 12'sd0) ? -v : v;
  endfunction

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          at_q;

  logic signed [10:0] tgt_in  [2];
  logic signed [10:0] cur_all [2];
  logic               idle_d  [2];

  assign tick      = (tick_cnt == TICK_LAST);
  assign tgt_in[0] = lft_tgt;
  assign tgt_in[1] = rht_tgt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_side
    side_st_t           st_q, st_d;
    logic signed [10:0] tgt_q, tgt_eff, cur_q, cur_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic signed [11:0] cur_x, tgt_x, diff;
    logic               rev;

    always_comb begin
      // a target captured this cycle already steers this cycle's decision
      tgt_eff = (tgt_vld && !estop) ? clamp_tgt(tgt_in[s]) : tgt_q;
      cur_x   = {cur_q[10], cur_q};
      tgt_x   = {tgt_eff[10], tgt_eff};
      diff    = tgt_x - cur_x;
      rev     = (cur_x > 12'sd0 && tgt_x < 12'sd0) || (cur_x < 12'sd0 && tgt_x > 12'sd0);
      st_d    = st_q;
      cur_d   = cur_q;
      hold_d  = hold_q;
      case (st_q)
        IDLE: begin
          if (tgt_eff != cur_q) st_d = RAMP;
        end
        RAMP: begin
          if (tick) begin
            if (rev) begin
              if (abs12(cur_x) <= STEP_S) begin
                cur_d  = '0;
                hold_d = '0;
                st_d   = HOLD;
              end else begin
                cur_d = sat12((cur_x > 12'sd0) ? cur_x - STEP_S : cur_x + STEP_S);
              end
            end else if (abs12(diff) <= STEP_S) begin
              cur_d = tgt_eff;
              st_d  = IDLE;
            end else begin
              cur_d = sat12((diff > 12'sd0) ? cur_x + STEP_S : cur_x - STEP_S);
            end
          end
        end
        HOLD: begin
          // dwell is counted in clocks and is never shortened by a retarget
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            st_d   = (tgt_eff == 11'sd0) ? IDLE : RAMP;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: st_d = IDLE;
      endcase
      if (estop) begin
        st_d   = IDLE;
        cur_d  = '0;
        hold_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q   <= IDLE;
        cur_q  <= '0;
        tgt_q  <= '0;
        hold_q <= '0;
      end else begin
        st_q   <= st_d;
        cur_q  <= cur_d;
        hold_q <= hold_d;
        tgt_q  <= estop ? 11'sd0 : tgt_eff;
      end
    end

    assign cur_all[s] = cur_q;
    assign idle_d[s]  = (st_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      at_q <= 1'b1;
    end else begin
      at_q <= idle_d[0] && idle_d[1];
    end
  end

  assign lft    = cur_all[0];
  assign rht    = cur_all[1];
  assign at_tgt = at_q;
  assign busy   = ~at_q;

endmodule

// File: doc/motor_ramp_sched.md
Name: motor_ramp_sched

Overview:
Slew-rate scheduler that sits in front of the left/right PWM motor driver and produces its 11-bit signed speed commands (lft/rht).
- Accepts target speeds from the line-follow/PID layer and ramps each side toward its target by a bounded step per tick.
- Forces a zero-speed brake dwell before any direction reversal, so the drive never flips polarity in one step.
- Provides an emergency stop that drops both commands to zero immediately.

Parameters:
STEP, 32, magnitude change applied per tick (1..1023)
TICK_DIV, 1000, clocks per ramp tick (>=2)
BRAKE_CYC, 256, clocks a side holds at 0 before reversing direction (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
lft_tgt  input  11  signed target speed, left
rht_tgt  input  11  signed target speed, right
tgt_vld  input  1  capture both targets this cycle
estop  input  1  emergency stop, level
lft  output  11  signed speed command to motor driver, left
rht  output  11  signed speed command to motor driver, right
at_tgt  output  1  both sides settled on target
busy  output  1  ~at_tgt

Behaviour:
Interface: one clock (clk); reset rst_n is synchronous and active-low. All state is updated on posedge clk only.

Reset (rst_n=0 at posedge):
- lft=rht=0; latched targets=0; both FSMs IDLE; tick counter=0; at_tgt=1, busy=0.
- Reset asserted mid-ramp or mid-hold aborts immediately with the same values.

Tick generation:
- tick_cnt free-runs 0..TICK_DIV-1 and wraps to 0.
- tick is asserted in the cycle where tick_cnt==TICK_DIV-1.
- Ramp steps occur only on tick cycles. The counter is not reset by tgt_vld or estop.

Target capture:
- When tgt_vld=1 and estop=0, both targets are registered.
- The value -1024 (0x400) is clamped to -1023; all other values are stored unchanged.
- A new target is accepted in any state and replaces the old one; the next decision uses the new value.

Per-side FSM (left and right are identical and independent; cur = lft or rht, tgt = latched target):
- IDLE: cur==tgt. Go to RAMP when tgt!=cur.
- RAMP, on tick only:
  - Reversal pending (cur>0 and tgt<0, or cur<0 and tgt>0): step toward 0. If |cur|<=STEP, set cur=0 and enter HOLD; otherwise cur -= sign(cur)*STEP. Zero is never crossed.
  - No reversal: if |tgt-cur|<=STEP, set cur=tgt and go to IDLE; otherwise cur += sign(tgt-cur)*STEP.
- HOLD: cur stays 0; hold_cnt counts BRAKE_CYC clocks (clock cycles, not ticks).
  - On expiry: go to IDLE if tgt==0, else RAMP.
  - A new target captured during HOLD does not shorten the dwell.

Arithmetic:
- Differences and sums are computed in 12-bit signed arithmetic.
- Results are saturated to [-1023, +1023] before registering.
- Outputs never take the value -1024.

Output timing:
- lft/rht are registered and change only on tick cycles or on estop.
- Latency: tgt_vld in cycle t produces the first output change at the first tick in cycle >= t+1.

Estop:
- While estop=1: lft=rht=0 from the next posedge, targets forced to 0, both FSMs IDLE, hold counters cleared, tgt_vld ignored.
- On deassertion: outputs stay 0 until a new tgt_vld.
- No brake dwell is required after estop, because the output is already 0.

Status:
- at_tgt=1 iff both FSMs are IDLE (equivalently lft==tgt_l and rht==tgt_r and neither side is in HOLD).
- at_tgt is registered and is valid the same cycle the outputs settle.

Simultaneous events:
- estop beats tgt_vld; tgt_vld beats the tick decision in the same cycle (the new target is used by that tick).
- rst_n beats everything.

Test Plan:
1. Reset, then tgt_vld with lft_tgt=100, rht_tgt=0, using TICK_DIV=4, STEP=32 -> lft goes 32,64,96,100 on successive ticks; rht stays 0; at_tgt=1 after the 4th tick.
2. From lft=100, tgt_vld with lft_tgt=-50, BRAKE_CYC=8 -> lft steps 68,36,4,0; holds 0 for 8 clocks; then -32,-50; lft never exceeds -50 or goes positive after the hold.
3. Saturation/clamp: tgt_vld with lft_tgt=0x400 (-1024) from 0, STEP=1023 -> lft=-1023 after one tick, never 0x400; rht_tgt=1023 -> rht=1023.
4. estop asserted while lft=500 is ramping toward 900 -> lft=rht=0 on the next posedge; after estop drops, outputs stay 0 until tgt_vld; tgt_vld during estop is ignored.
5. Retarget mid-ramp: ramping 0->600, new tgt_vld 200 when lft=256 -> lft steps down 224, 200; no HOLD (same sign); at_tgt rises at 200.
6. Synchronous reset asserted during HOLD (rst_n low for 1 clock) -> all outputs 0, at_tgt=1 at the next posedge; an async pulse of rst_n between edges has no effect.
